kf8259_priority_acknowledge_controller: RTL and testbench
=========================================================

Name: kf8259_priority_acknowledge_controller

Overview:
- Sits between the 8259 request latch (IRR) and the CPU bus interface.
- Resolves the highest-priority unmasked request against the in-service register (ISR) using rotating priority, and raises INT to the CPU.
- Sequences the 8086-style two-pulse INTA cycle and drives the request latch's freeze and clear inputs.
- Executes EOI and set-priority commands from the command decoder, and supplies the interrupt vector byte.

Parameters:
- RESET_LOWEST_PRIORITY, 3'd7: priority_rotate value after reset, so IR0 is highest priority.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- interrupt_request_register  in  8  IRR from the request latch
- interrupt_mask  in  8  IMR; 1 = masked
- interrupt_acknowledge_n  in  1  CPU INTA, active low
- vector_base  in  5  T7..T3 of the vector (from ICW2)
- eoi_strobe  in  1  one-cycle EOI command
- eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific
- eoi_rotate  in  1  rotate priority on this EOI
- eoi_level  in  3  level for a specific EOI
- set_priority_strobe  in  1  one-cycle set-priority command
- set_priority_level  in  3  new lowest-priority level
- interrupt_to_cpu  out  1  INT
- freeze  out  1  to request latch: hold IRR
- clear_interrupt_request  out  8  to request latch: one-hot, one-cycle clear
- in_service_register  out  8  ISR
- priority_rotate  out  3  current lowest-priority level
- vector_out  out  8  vector byte
- vector_out_enable  out  1  vector_out valid for the bus

Behaviour:
- Reset values: every output 0, except priority_rotate = RESET_LOWEST_PRIORITY.
- Reset mid-sequence aborts immediately to IDLE; ISR is cleared.

Priority rule:
- Level L has rank (L - priority_rotate - 1) mod 8; rank 0 is highest.
- Candidates = IRR & ~mask. The winner is the lowest-rank candidate.
- INT condition: a winner exists and its rank is strictly lower than the rank of the lowest-rank ISR bit. An empty ISR counts as rank 8.
- interrupt_to_cpu is registered, giving 1 cycle of latency. It is forced to 0 outside IDLE.

INTA edge detection: interrupt_acknowledge_n is registered to prev_inta_n. Falling edge = prev 1 and current 0; rising edge = prev 0 and current 1.

FSM states:
- IDLE: on a falling edge, go to ACK1. At that same edge:
  - latch the winner into ack_level;
  - set ISR[ack_level];
  - drive clear_interrupt_request to one-hot(ack_level) for exactly one cycle;
  - set freeze to 1 and interrupt_to_cpu to 0.
  - No winner (spurious): ack_level = 7, ISR unchanged, clear_interrupt_request = 0.
- ACK1: on a rising edge, go to WAIT2.
- WAIT2: on a falling edge, go to ACK2. vector_out = {vector_base, ack_level}; vector_out_enable = 1.
- ACK2: on a rising edge, go to IDLE. vector_out_enable = 0, freeze = 0. vector_out holds its last value.

EOI and priority commands (accepted in any state):
- Non-specific EOI clears the lowest-rank ISR bit. It is a no-op if ISR is 0.
- Specific EOI clears ISR[eoi_level].
- With eoi_rotate = 1, priority_rotate becomes the cleared level. A non-specific EOI with an empty ISR does not rotate.
- set_priority_strobe loads priority_rotate from set_priority_level.

Simultaneous events:
- If an ISR set and an EOI clear hit the same bit in one cycle, the set wins.
- If set_priority_strobe and a rotating EOI occur together, set_priority_strobe wins.
- Priority for the ACK1 resolution uses the pre-edge priority_rotate.

Optional Feature:
- Macro: KF8259_AUTO_EOI_EN.
- Defined: adds input auto_eoi_config (1 bit). When it is 1, the ACK2 rising edge performs a non-specific-style clear of ISR[ack_level]. This happens in the same cycle freeze drops, and it rotates if eoi_rotate is held high.
- Undefined: no port and no auto clear; ISR bits are cleared only by explicit EOI.

Test Plan:
- Reset, then IRR = 8'h28, mask = 0:
  - interrupt_to_cpu = 1 one cycle later.
  - First INTA: ISR = 8'h08, clear_interrupt_request = 8'h08 for one cycle, freeze = 1.
  - Second INTA with vector_base = 5'h01: vector_out = 8'h0B, enable only while INTA is low.
- ISR = 8'h08 with IRR = 8'h10: INT stays 0. Then raise IRR bit 1: INT = 1 (nesting).
- priority_rotate = 3, IRR = 8'h11, ISR = 0: winner is IR4, so vector low bits = 3'd4.
- INTA with IRR = 0 (spurious): ack_level = 7, ISR unchanged, no clear pulse, vector low bits = 3'b111.
- Non-specific EOI with eoi_rotate, ISR = 8'h0A: ISR = 8'h08, priority_rotate = 1. Specific EOI level 3: ISR = 0.
- Reset asserted while in WAIT2: next cycle freeze = 0, ISR = 0, vector_out_enable = 0, state IDLE. KF8259_AUTO_EOI_EN build: ISR bit clears at the second INTA rise.

Source files
------------

// File: rtl/kf8259_priority_acknowledge_controller.sv
// 8259 priority resolver and INTA sequencer: rotating priority against the ISR, INT generation,
// two-pulse INTA handling, EOI/set-priority commands and vector byte. Auto-EOI: KF8259_AUTO_EOI_EN.
module kf8259_priority_acknowledge_controller #(
    parameter logic [2:0] RESET_LOWEST_PRIORITY = 3'd7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] vector_base,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       set_priority_strobe,
    input  logic [2:0] set_priority_level,
`ifdef KF8259_AUTO_EOI_EN
    input  logic       auto_eoi_config,
`endif
    output logic       interrupt_to_cpu,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [2:0] priority_rotate,
    output logic [7:0] vector_out,
    output logic       vector_out_enable
);

    localparam int unsigned NUM_LEVELS = 8;
    localparam int unsigned LEVEL_W    = 3;
    localparam int unsigned RANK_W     = 4;
    localparam int unsigned VEC_W      = 8;
    localparam logic [LEVEL_W-1:0] SPURIOUS_LEVEL = 3'd7;
    localparam logic [RANK_W-1:0]  NO_RANK        = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    prev_inta_n_q;
    logic [NUM_LEVELS-1:0]   isr_q, isr_d;
    logic [LEVEL_W-1:0]      rotate_q, rotate_d;
    logic [LEVEL_W-1:0]      ack_level_q, ack_level_d;
    logic                    int_q, int_d;
    logic                    freeze_q, freeze_d;
    logic [NUM_LEVELS-1:0]   clear_q, clear_d;
    logic [VEC_W-1:0]        vector_q, vector_d;
    logic                    vec_en_q, vec_en_d;

    logic [NUM_LEVELS-1:0]   candidates;
    logic                    win_valid;
    logic [LEVEL_W-1:0]      win_level;
    logic [RANK_W-1:0]       win_rank;
    logic                    isr_valid;
    logic [LEVEL_W-1:0]      isr_level;
    logic [RANK_W-1:0]       isr_rank;
    logic                    inta_fall;
    logic                    inta_rise;

    assign candidates = interrupt_request_register & ~interrupt_mask;
    assign inta_fall  = prev_inta_n_q & ~interrupt_acknowledge_n;
    assign inta_rise  = ~prev_inta_n_q & interrupt_acknowledge_n;

    // Walk levels from rank 0 upward; the first hit is the highest-priority candidate.
    always_comb begin
        logic [LEVEL_W-1:0] lvl;
        win_valid = 1'b0;
        win_level = SPURIOUS_LEVEL;
        win_rank  = NO_RANK;
        lvl       = '0;
        for (int unsigned r = 0; r < NUM_LEVELS; r++) begin
            lvl = rotate_q + LEVEL_W'(r) + LEVEL_W'(1);
            if (candidates[lvl] && !win_valid) begin
                win_valid = 1'b1;
                win_level = lvl;
                win_rank  = RANK_W'(r);
            end
        end
    end

    // Highest-priority in-service level; an empty ISR reports rank 8.
    always_comb begin
        logic [LEVEL_W-1:0] lvl;
        isr_valid = 1'b0;
        isr_level = '0;
        isr_rank  = NO_RANK;
        lvl       = '0;
        for (int unsigned r = 0; r < NUM_LEVELS; r++) begin
            lvl = rotate_q + LEVEL_W'(r) + LEVEL_W'(1);
            if (isr_q[lvl] && !isr_valid) begin
                isr_valid = 1'b1;
                isr_level = lvl;
                isr_rank  = RANK_W'(r);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        isr_d       = isr_q;
        rotate_d    = rotate_q;
        ack_level_d = ack_level_q;
        int_d       = 1'b0;
        freeze_d    = freeze_q;
        clear_d     = '0;
        vector_d    = vector_q;
        vec_en_d    = vec_en_q;

        if (eoi_strobe) begin
            if (eoi_specific) begin
                isr_d[eoi_level] = 1'b0;
                if (eoi_rotate) begin
                    rotate_d = eoi_level;
                end
            end else if (isr_valid) begin
                isr_d[isr_level] = 1'b0;
                if (eoi_rotate) begin
                    rotate_d = isr_level;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (inta_fall) begin
                    state_d     = ST_ACK1;
                    ack_level_d = win_level;
                    freeze_d    = 1'b1;
                    if (win_valid) begin
                        clear_d[win_level] = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_d  = ST_ACK2;
                    vector_d = {vector_base, ack_level_q};
                    vec_en_d = 1'b1;
                end
            end
            ST_ACK2: begin
                if (inta_rise) begin
                    state_d  = ST_IDLE;
                    vec_en_d = 1'b0;
                    freeze_d = 1'b0;
`ifdef KF8259_AUTO_EOI_EN
                    if (auto_eoi_config) begin
                        isr_d[ack_level_q] = 1'b0;
                        if (eoi_rotate) begin
                            rotate_d = ack_level_q;
                        end
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (set_priority_strobe) begin
            rotate_d = set_priority_level;
        end

        // The acknowledge set is applied last so it overrides a same-cycle EOI clear.
        isr_d = isr_d | clear_d;
        int_d = (state_d == ST_IDLE) && win_valid && (win_rank < isr_rank);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prev_inta_n_q <= 1'b1;
            isr_q         <= '0;
            rotate_q      <= RESET_LOWEST_PRIORITY;
            ack_level_q   <= '0;
            int_q         <= 1'b0;
            freeze_q      <= 1'b0;
            clear_q       <= '0;
            vector_q      <= '0;
            vec_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_inta_n_q <= interrupt_acknowledge_n;
            isr_q         <= isr_d;
            rotate_q      <= rotate_d;
            ack_level_q   <= ack_level_d;
            int_q         <= int_d;
            freeze_q      <= freeze_d;
            clear_q       <= clear_d;
            vector_q      <= vector_d;
            vec_en_q      <= vec_en_d;
        end
    end

    assign interrupt_to_cpu        = int_q;
    assign freeze                  = freeze_q;
    assign clear_interrupt_request = clear_q;
    assign in_service_register     = isr_q;
    assign priority_rotate         = rotate_q;
    assign vector_out              = vector_q;
    assign vector_out_enable       = vec_en_q;

endmodule

// File: tb/tb_kf8259_priority_acknowledge_controller.sv
// Bench for kf8259_priority_acknowledge_controller: directed scenarios then random traffic,
// every cycle compared against a rank-arithmetic reference model.
module tb_kf8259_priority_acknowledge_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr, mask;
    logic       inta_n;
    logic [4:0] vbase;
    logic       eoi_strobe, eoi_specific, eoi_rotate;
    logic [2:0] eoi_level;
    logic       sp_strobe;
    logic [2:0] sp_level;
`ifdef KF8259_AUTO_EOI_EN
    logic       auto_eoi;
`endif
    logic       int_o, freeze_o, ven_o;
    logic [7:0] clear_o, isr_o, vec_o;
    logic [2:0] rot_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] m_isr, m_clear, m_vec;
    int         m_rot, m_phase, m_ack;
    logic       m_int, m_freeze, m_ven, m_prev;

    kf8259_priority_acknowledge_controller dut (
        .clock                      (clk),
        .reset                      (reset),
        .interrupt_request_register (irr),
        .interrupt_mask             (mask),
        .interrupt_acknowledge_n    (inta_n),
        .vector_base                (vbase),
        .eoi_strobe                 (eoi_strobe),
        .eoi_specific               (eoi_specific),
        .eoi_rotate                 (eoi_rotate),
        .eoi_level                  (eoi_level),
        .set_priority_strobe        (sp_strobe),
        .set_priority_level         (sp_level),
`ifdef KF8259_AUTO_EOI_EN
        .auto_eoi_config            (auto_eoi),
`endif
        .interrupt_to_cpu           (int_o),
        .freeze                     (freeze_o),
        .clear_interrupt_request    (clear_o),
        .in_service_register        (isr_o),
        .priority_rotate            (rot_o),
        .vector_out                 (vec_o),
        .vector_out_enable          (ven_o)
    );

    always #5 clk = ~clk;

    function automatic int rank(input int lvl, input int rot);
        return ((lvl - rot - 1) % 8 + 8) % 8;
    endfunction

    // Level with the smallest rank among set bits, or -1 if none.
    function automatic int best(input logic [7:0] bits, input int rot);
        int b = -1;
        for (int l = 0; l < 8; l++)
            if (bits[l] && (b < 0 || rank(l, rot) < rank(b, rot))) b = l;
        return b;
    endfunction

    // Phase counts INTA edges seen: 0 wait 1st fall, 1 wait 1st rise, 2 wait 2nd fall, 3 wait 2nd rise.
    task automatic model_step();
        int w, lo, wr, lr;
        logic fall, rise;
        if (reset) begin
            m_isr = 0; m_clear = 0; m_vec = 0; m_rot = 7; m_phase = 0; m_ack = 0;
            m_int = 0; m_freeze = 0; m_ven = 0; m_prev = 1;
        end else begin
            fall = m_prev && !inta_n;
            rise = !m_prev && inta_n;
            w  = best(irr & ~mask, m_rot);
            lo = best(m_isr, m_rot);
            wr = (w >= 0) ? rank(w, m_rot) : 8;
            lr = (lo >= 0) ? rank(lo, m_rot) : 8;
            m_clear = 0;
            if (eoi_strobe) begin
                if (eoi_specific) begin
                    m_isr[eoi_level] = 1'b0;
                    if (eoi_rotate) m_rot = int'(eoi_level);
                end else if (lo >= 0) begin
                    m_isr[lo] = 1'b0;
                    if (eoi_rotate) m_rot = lo;
                end
            end
            if (m_phase == 0 && fall) begin
                m_phase = 1; m_freeze = 1;
                m_ack = (w >= 0) ? w : 7;
                if (w >= 0) m_clear[w] = 1'b1;
            end else if (m_phase == 1 && rise) begin
                m_phase = 2;
            end else if (m_phase == 2 && fall) begin
                m_phase = 3; m_ven = 1;
                m_vec = {vbase, 3'(m_ack)};
            end else if (m_phase == 3 && rise) begin
                m_phase = 0; m_ven = 0; m_freeze = 0;
`ifdef KF8259_AUTO_EOI_EN
                if (auto_eoi) begin
                    m_isr[m_ack] = 1'b0;
                    if (eoi_rotate) m_rot = m_ack;
                end
`endif
            end
            if (sp_strobe) m_rot = int'(sp_level);
            m_isr = m_isr | m_clear;
            m_int = (m_phase == 0) && (w >= 0) && (wr < lr);
            m_prev = inta_n;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic check_all();
        chk("int",    {7'b0, int_o},    {7'b0, m_int});
        chk("freeze", {7'b0, freeze_o}, {7'b0, m_freeze});
        chk("clear",  clear_o,          m_clear);
        chk("isr",    isr_o,            m_isr);
        chk("rotate", {5'b0, rot_o},    8'(m_rot));
        chk("vector", vec_o,            m_vec);
        chk("ven",    {7'b0, ven_o},    {7'b0, m_ven});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Full two-pulse INTA; captures ISR/clear after the first fall and vector after the second.
    task automatic inta_cycle(output logic [7:0] isr1, output logic [7:0] clr1, output logic [7:0] vec2);
        inta_n = 1'b0; tick();
        isr1 = isr_o; clr1 = clear_o;
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        vec2 = vec_o;
        inta_n = 1'b1; tick();
    endtask

    logic [7:0] c_isr, c_clr, c_vec;

    initial begin
        reset = 1; irr = 0; mask = 0; inta_n = 1; vbase = 0;
        eoi_strobe = 0; eoi_specific = 0; eoi_rotate = 0; eoi_level = 0;
        sp_strobe = 0; sp_level = 0;
`ifdef KF8259_AUTO_EOI_EN
        auto_eoi = 0;
`endif
        tick(); tick();
        reset = 0; tick();
        chk("rst_rot", {5'b0, rot_o}, 8'h07);
        chk("rst_isr", isr_o, 8'h00);

        irr = 8'h28; tick();
        chk("tp_int", {7'b0, int_o}, 8'h01);
        inta_n = 0; tick();
        chk("tp_isr", isr_o, 8'h08);
        chk("tp_clr", clear_o, 8'h08);
        chk("tp_frz", {7'b0, freeze_o}, 8'h01);
        tick();
        chk("tp_clr_once", clear_o, 8'h00);
        inta_n = 1; tick();
        vbase = 5'h01; inta_n = 0; tick();
        chk("tp_vec", vec_o, 8'h0B);
        chk("tp_ven", {7'b0, ven_o}, 8'h01);
        inta_n = 1; tick();
        chk("tp_ven_off", {7'b0, ven_o}, 8'h00);
        chk("tp_vec_hold", vec_o, 8'h0B);

        irr = 8'h10; tick(); tick();
        chk("nest_low", {7'b0, int_o}, 8'h00);
        irr = 8'h12; tick();
        chk("nest_high", {7'b0, int_o}, 8'h01);
        inta_cycle(c_isr, c_clr, c_vec);
        chk("nest_isr", isr_o, 8'h0A);
        irr = 8'h00;

        eoi_strobe = 1; eoi_specific = 0; eoi_rotate = 1; tick();
        chk("nseoi_isr", isr_o, 8'h08);
        chk("nseoi_rot", {5'b0, rot_o}, 8'h01);
        eoi_specific = 1; eoi_rotate = 0; eoi_level = 3; tick();
        eoi_strobe = 0;
        chk("seoi_isr", isr_o, 8'h00);

        sp_strobe = 1; sp_level = 3; tick();
        sp_strobe = 0;
        chk("setpri", {5'b0, rot_o}, 8'h03);
        irr = 8'h11;
        inta_cycle(c_isr, c_clr, c_vec);
        chk("rot_win_isr", c_isr, 8'h10);
        chk("rot_vec_lo", {5'b0, c_vec[2:0]}, 8'h04);
        irr = 8'h00;
        eoi_strobe = 1; eoi_specific = 1; eoi_level = 4; tick();
        eoi_strobe = 0;

        irr = 8'h04;
        inta_cycle(c_isr, c_clr, c_vec);
        irr = 8'h00; tick();
        inta_cycle(c_isr, c_clr, c_vec);
        chk("spur_isr", c_isr, 8'h04);
        chk("spur_clr", c_clr, 8'h00);
        chk("spur_vec", c_vec, 8'h0F);
        eoi_strobe = 1; eoi_specific = 1; eoi_level = 2; tick();
        eoi_strobe = 0;
        chk("spur_eoi", isr_o, 8'h00);

        irr = 8'h01;
        inta_n = 0; tick();
        inta_n = 1; tick();
        reset = 1; tick();
        chk("rstw_frz", {7'b0, freeze_o}, 8'h00);
        chk("rstw_isr", isr_o, 8'h00);
        chk("rstw_ven", {7'b0, ven_o}, 8'h00);
        reset = 0; tick();
        chk("rstw_idle_int", {7'b0, int_o}, 8'h01);

`ifdef KF8259_AUTO_EOI_EN
        auto_eoi = 1;
        inta_cycle(c_isr, c_clr, c_vec);
        chk("aeoi_set", c_isr, 8'h01);
        chk("aeoi_clr", isr_o, 8'h00);
        auto_eoi = 0;
`else
        inta_cycle(c_isr, c_clr, c_vec);
        chk("noaeoi_isr", isr_o, 8'h01);
`endif

        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (reset) inta_n = 1'b1;
            else if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
            if ($urandom_range(0, 3) == 0) irr = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) vbase = 5'($urandom);
            eoi_strobe   = ($urandom_range(0, 5) == 0);
            eoi_specific = 1'($urandom);
            eoi_rotate   = 1'($urandom);
            eoi_level    = 3'($urandom);
            sp_strobe    = ($urandom_range(0, 11) == 0);
            sp_level     = 3'($urandom);
`ifdef KF8259_AUTO_EOI_EN
            auto_eoi     = 1'($urandom);
`endif
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
